pcd_extract: RTL and testbench

- Payload channel decode-side extractor; the receive-end counterpart of the payload channel encoder.
- Accepts a serial systematic codeword of INFO_LEN information bits followed by PAR_LEN parity bits.
- Buffers the information bits, discards the parity bits, then replays the information bits in order once the full frame has arrived.
- Sits between the demapper hard-bit output and the payload descrambler/sink.

---
 rtl/pcd_extract.sv | 163 ++++++++++++++++
 tb/tb_pcd_extract.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcd_extract.sv
// pcd_extract: buffers the information part of a serial systematic codeword, drops the parity
// part, then replays the information bits in arrival order. PCD_TIMEOUT_EN adds an idle watchdog.
module pcd_extract #(
    parameter int INFO_LEN = 4320,
    parameter int PAR_LEN  = 4320,
    parameter int ADDR_W   = 13,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        din,
    input  logic        din_valid,
    output logic        dout,
    output logic        dout_valid,
    output logic        decode_busy,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);
    localparam int RAM_AW = (INFO_LEN > 1) ? $clog2(INFO_LEN) : 1;
    localparam logic [ADDR_W-1:0] INFO_LAST = ADDR_W'(INFO_LEN - 1);
    localparam logic [ADDR_W-1:0] PAR_LAST  = ADDR_W'(PAR_LEN - 1);

    typedef enum logic [1:0] {IDLE, RX_INFO, RX_PAR, REPLAY} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic [ADDR_W-1:0] par_cnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_vld_q;
    logic              rd_data_q;
    logic              dout_q;
    logic              dout_valid_q;
    logic              frame_err_q;
    logic [15:0]       frame_cnt_q;

    logic              ram_we_d;
    logic [ADDR_W-1:0] ram_wa_d;
    logic              mem [INFO_LEN];

`ifdef PCD_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    logic [IDLE_W-1:0] idle_cnt_q;
`else
    // No watchdog: a stalled frame simply waits for more beats.
`endif

    always_comb begin
        ram_we_d = 1'b0;
        ram_wa_d = wr_cnt_q;
        if (!flush && din_valid) begin
            if (state_q == IDLE) begin
                ram_we_d = 1'b1;
                ram_wa_d = '0;
            end else if (state_q == RX_INFO) begin
                ram_we_d = 1'b1;
            end
        end
    end

    // Buffer RAM: no reset, synchronous read with one cycle of latency.
    always_ff @(posedge clk) begin
        if (ram_we_d) mem[ram_wa_d[RAM_AW-1:0]] <= din;
        rd_data_q <= mem[rd_addr_q[RAM_AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_cnt_q     <= '0;
            par_cnt_q    <= '0;
            rd_addr_q    <= '0;
            rd_vld_q     <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
`ifdef PCD_TIMEOUT_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
            rd_vld_q     <= 1'b0;
            dout_valid_q <= rd_vld_q;
            dout_q       <= rd_vld_q & rd_data_q;
            if (flush) begin
                state_q      <= IDLE;
                wr_cnt_q     <= '0;
                par_cnt_q    <= '0;
                rd_addr_q    <= '0;
                dout_q       <= 1'b0;
                dout_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (din_valid) begin
                        if (INFO_LEN == 1) begin
                            state_q   <= RX_PAR;
                            par_cnt_q <= '0;
                        end else begin
                            state_q  <= RX_INFO;
                            wr_cnt_q <= ADDR_W'(1);
                        end
                    end
                    RX_INFO: if (din_valid) begin
                        if (wr_cnt_q == INFO_LAST) begin
                            state_q   <= RX_PAR;
                            wr_cnt_q  <= '0;
                            par_cnt_q <= '0;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                    RX_PAR: if (din_valid) begin
                        if (par_cnt_q == PAR_LAST) begin
                            state_q     <= REPLAY;
                            par_cnt_q   <= '0;
                            rd_addr_q   <= '0;
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end else begin
                            par_cnt_q <= par_cnt_q + 1'b1;
                        end
                    end
                    REPLAY: begin
                        rd_vld_q <= 1'b1;
                        // Upstream must not send while busy; such a beat is dropped and flagged.
                        if (din_valid) frame_err_q <= 1'b1;
                        if (rd_addr_q == INFO_LAST) begin
                            state_q   <= IDLE;
                            rd_addr_q <= '0;
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
`ifdef PCD_TIMEOUT_EN
            if (!flush && (state_q == RX_INFO || state_q == RX_PAR)) begin
                if (din_valid) begin
                    idle_cnt_q <= '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_q     <= IDLE;
                    wr_cnt_q    <= '0;
                    par_cnt_q   <= '0;
                    idle_cnt_q  <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    idle_cnt_q <= idle_cnt_q + 1'b1;
                end
            end else begin
                idle_cnt_q <= '0;
            end
`endif
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign decode_busy = (state_q == REPLAY) | dout_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_pcd_extract.sv
// Bench for pcd_extract with 8 info + 8 parity bits: directed scenarios plus random frames,
// checked against a queue model of the expected replay stream.
module tb_pcd_extract;
    localparam int IL = 8;
    localparam int PL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        dout;
    logic        dout_valid;
    logic        decode_busy;
    logic        frame_err;
    logic [15:0] frame_cnt;

    pcd_extract #(.INFO_LEN(IL), .PAR_LEN(PL), .ADDR_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .decode_busy(decode_busy),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];
    logic [0:0] out_q[$];
    logic [0:0] info_q[$];
    int first_cyc = -1;
    int err_cnt = 0;
    int err_cyc = -1;
    int last_edge = 0;
    int fc_exp = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dout_valid) begin
            out_q.push_back(dout);
            if (!prev_valid && first_cyc < 0) first_cyc = cyc;
            chk("busy_during_valid", {31'd0, decode_busy}, 32'd1);
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        prev_valid = dout_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic beat(input logic b);
        din = b;
        din_valid = 1'b1;
        step();
        last_edge = cyc;
        din_valid = 1'b0;
    endtask

    task automatic start_frame();
        out_q.delete();
        first_cyc = -1;
        err_cnt = 0;
        err_cyc = -1;
    endtask

    task automatic rand_info();
        info_q.delete();
        for (int i = 0; i < IL; i++) info_q.push_back(1'($urandom));
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle after each beat, 2 random idle run
    task automatic send_frame(input int gap_mode);
        exp_q = info_q;
        for (int i = 0; i < IL + PL; i++) begin
            beat(i < IL ? info_q[i] : 1'($urandom));
            if (i != IL + PL - 1) begin
                if (gap_mode == 1) idle(1);
                else if (gap_mode == 2) idle($urandom_range(0, 3));
            end
        end
        fc_exp++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((decode_busy || dout_valid) && n < 60) begin
            step();
            n++;
        end
        chk("drain_bound", {31'd0, n < 60}, 32'd1);
        step();
    endtask

    task automatic check_frame(input int exp_err);
        chk("out_len", out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("dout[%0d]", i), {31'd0, (i < out_q.size()) ? out_q[i] : 1'bx},
                {31'd0, exp_q[i]});
        chk("first_valid_latency", first_cyc, last_edge + 2);
        chk("frame_cnt", {16'd0, frame_cnt}, fc_exp & 32'hffff);
        chk("frame_err_pulses", err_cnt, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ovr_edge;
        int k;
        repeat (3) step();
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_busy", {31'd0, decode_busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        start_frame();
        info_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        send_frame(0);
        wait_drain();
        check_frame(0);

        start_frame();
        send_frame(1);
        wait_drain();
        check_frame(0);

        for (int f = 0; f < 3; f++) begin
            rand_info();
            start_frame();
            send_frame(2);
            wait_drain();
            check_frame(0);
        end

        rand_info();
        start_frame();
        send_frame(0);
        ovr_edge = last_edge + 4;
        idle(3);
        din = 1'b1;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        wait_drain();
        check_frame(1);
        chk("overrun_err_time", err_cyc, ovr_edge);

        rand_info();
        start_frame();
        send_frame(0);
        wait_drain();
        check_frame(0);

        start_frame();
        for (int i = 0; i < 5; i++) beat(1'($urandom));
        flush = 1'b1;
        step();
        flush = 1'b0;
        info_q.delete();
        for (int i = 0; i < IL; i++) info_q.push_back(1'b1);
        send_frame(0);
        wait_drain();
        check_frame(0);

        rand_info();
        start_frame();
        send_frame(0);
        k = 0;
        while (out_q.size() < 3 && k < 40) begin
            step();
            k++;
        end
        chk("reset_wait_bound", {31'd0, k < 40}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("arst_busy", {31'd0, decode_busy}, 32'd0);
        chk("arst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("arst_dout", {31'd0, dout}, 32'd0);
        fc_exp = 0;
        step();
        rst_n = 1'b1;
        step();
        rand_info();
        start_frame();
        send_frame(0);
        wait_drain();
        check_frame(0);

`ifdef PCD_TIMEOUT_EN
        start_frame();
        for (int i = 0; i < 10; i++) beat(1'($urandom));
        ovr_edge = last_edge + 4;
        idle(12);
        chk("timeout_err_pulses", err_cnt, 1);
        chk("timeout_err_time", err_cyc, ovr_edge);
        chk("timeout_no_output", out_q.size(), 0);
        chk("timeout_frame_cnt", {16'd0, frame_cnt}, fc_exp & 32'hffff);
        rand_info();
        start_frame();
        send_frame(0);
        wait_drain();
        check_frame(0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
